motion_seg_queue: RTL and testbench
===================================

// Module: motion_seg_queue
// PURPOSE
//  Segment queue and sequencer directly upstream of the acceleration step generator.
//  Software/bus logic pushes (dt, steps) segments into a FIFO; this block loads them into the generator.
//  Consecutive segments chain with zero idle cycles: the next load coincides with the generator's done strobe.
//  It also flags underrun, overflow and illegal segments, counts completed segments and handles abort.
// PARAMETERS
//  DEPTH_LOG2  4   FIFO depth = 2**DEPTH_LOG2 segments (range 1..8)
// PORTS
//  clk          in   1   system clock; all state updates on rising edge
//  reset        in   1   synchronous, active-high; clears all state
//  wr_dt        in   32  segment period in clocks per step; must be >= 1
//  wr_steps     in   32  segment step count; must be >= 1
//  wr_en        in   1   push request for {wr_dt, wr_steps}
//  run          in   1   level: 1 = sequencing enabled; 0 = hold, no new loads
//  abort        in   1   one-cycle pulse: flush FIFO and stop generator
//  clr_flags    in   1   one-cycle pulse: clears overflow/underrun/bad_seg
//  gen_done     in   1   generator done strobe (combinatorial, last-step cycle)
//  gen_stopped  in   1   generator stopped flag (registered)
//  dt_val       out  32  FIFO head dt; valid whenever load=1
//  steps_val    out  32  FIFO head steps; valid whenever load=1
//  load         out  1   load strobe to generator (combinatorial)
//  gen_reset    out  1   registered one-cycle stop pulse to generator reset
//  full         out  1   FIFO full
//  level        out  DEPTH_LOG2+1  FIFO occupancy, 0..2**DEPTH_LOG2
//  busy         out  1   state != IDLE
//  seg_count    out  32  segments completed since reset (wraps at 2**32)
//  overflow     out  1   sticky: push attempted while full
//  underrun     out  1   sticky: segment finished with FIFO empty and run=1
//  bad_seg      out  1   sticky: push with wr_dt==0 or wr_steps==0 (rejected)
// BEHAVIOUR
//  Reset: FIFO empty, level=0, full=0, state IDLE, load=0, gen_reset=0, seg_count=0, all flags 0.
//  FIFO: show-ahead, head entry drives dt_val/steps_val directly.
//  Push accepted iff wr_en & !full & wr_dt!=0 & wr_steps!=0; entry visible at head on next cycle.
//  wr_en & full -> entry dropped, overflow<=1; wr_en & zero field -> dropped, bad_seg<=1 (both if both).
//  Pop occurs exactly on cycles with load=1. Push and pop in the same cycle: level unchanged; allowed when full.
//  load = run & !abort & level!=0 & ((state==IDLE & gen_stopped) | (state==RUN & gen_done)).
//  FSM states: IDLE, RUN, ABORT.
//   IDLE: load -> RUN. Otherwise stay.
//   RUN: gen_done & load -> RUN (chained, seg_count+1).
//        gen_done & !load -> IDLE, seg_count+1; underrun<=1 if run=1 and level==0.
//        run=0 does not stop the current segment; it only suppresses the next load.
//   ABORT: entered from any state on abort; FIFO flushed (level<=0); gen_reset=1 for exactly this cycle;
//          next cycle -> IDLE. A gen_done coinciding with abort is not counted.
//  abort has priority over push: a push in the abort cycle is discarded, no flag set.
//  clr_flags clears flags; a flag-setting event in the same cycle wins (flag stays 1).
//  seg_count increments by 1 per gen_done seen in RUN; 0xFFFFFFFF+1 -> 0.
//  Latency: push at cycle N -> earliest load at N+1 (IDLE, gen_stopped=1, run=1).
//  Reset mid-segment: all state cleared; generator is reset by the same reset net.
// TESTING
//  Push (dt=3,steps=2), run=1 -> load at cycle 1, gen_done 6 cycles later, seg_count=1, IDLE, no underrun.
//  Push 3 segments (2,2),(1,3),(4,1) -> 3 loads, each 2nd/3rd load in same cycle as gen_done; seg_count=3.
//  Fill 16 entries, 17th push -> full=1, level=16, overflow=1, 17th entry never loaded.
//  Single segment with run held 1, FIFO empty at gen_done -> underrun=1, IDLE; clr_flags -> underrun=0.
//  Push wr_steps=0 then wr_dt=0 -> bad_seg=1, level stays 0, no load issued.
//  Run with 5 queued, abort mid-segment -> gen_reset=1 one cycle, level=0, IDLE next cycle, no further load.

Source files
------------

// File: rtl/motion_seg_queue.sv
// Segment FIFO and load sequencer in front of the acceleration step generator.
// Chains queued (dt, steps) segments into the generator with no idle cycles and tracks error flags.
module motion_seg_queue #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           wr_dt,
    input  logic [31:0]           wr_steps,
    input  logic                  wr_en,
    input  logic                  run,
    input  logic                  abort,
    input  logic                  clr_flags,
    input  logic                  gen_done,
    input  logic                  gen_stopped,
    output logic [31:0]           dt_val,
    output logic [31:0]           steps_val,
    output logic                  load,
    output logic                  gen_reset,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  busy,
    output logic [31:0]           seg_count,
    output logic                  overflow,
    output logic                  underrun,
    output logic                  bad_seg
);

    localparam int                 DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] CNT_ONE   = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = CNT_ONE << DEPTH_LOG2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ABORT = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]    count_q, count_d;
    logic [31:0]            seg_count_q, seg_count_d;
    logic                   gen_reset_q, gen_reset_d;
    logic                   overflow_q, overflow_d;
    logic                   underrun_q, underrun_d;
    logic                   bad_seg_q, bad_seg_d;
    logic [63:0]            mem_q [DEPTH];

    logic                   full_s;
    logic                   empty_s;
    logic                   load_s;
    logic                   push_s;
    logic                   fields_ok_s;
    logic                   ovf_evt_s;
    logic                   bad_evt_s;
    logic                   und_evt_s;
    logic                   seg_done_s;

    always_comb begin
        full_s      = (count_q == DEPTH_CNT);
        empty_s     = (count_q == '0);
        fields_ok_s = (wr_dt != 32'd0) && (wr_steps != 32'd0);
        load_s      = run && !abort && !empty_s &&
                      (((state_q == ST_IDLE) && gen_stopped) ||
                       ((state_q == ST_RUN) && gen_done));
        // A full FIFO still accepts a push when the head is popped in the same cycle
        push_s      = wr_en && !abort && fields_ok_s && (!full_s || load_s);
        ovf_evt_s   = wr_en && !abort && full_s && !load_s;
        bad_evt_s   = wr_en && !abort && !fields_ok_s;
        seg_done_s  = (state_q == ST_RUN) && gen_done && !abort;
        und_evt_s   = seg_done_s && !load_s && run && empty_s;

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (abort) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (load_s) begin
                rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (push_s && !load_s) begin
                count_d = count_q + CNT_ONE;
            end else if (load_s && !push_s) begin
                count_d = count_q - CNT_ONE;
            end else begin
                count_d = count_q;
            end
        end

        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (load_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (gen_done && !load_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_ABORT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d = ST_ABORT;
        end else begin
            state_d = state_d;
        end

        gen_reset_d = abort;
        if (seg_done_s) begin
            seg_count_d = seg_count_q + 32'd1;
        end else begin
            seg_count_d = seg_count_q;
        end

        // A flag-setting event in the clear cycle keeps the flag set
        overflow_d = ovf_evt_s || (overflow_q && !clr_flags);
        underrun_d = und_evt_s || (underrun_q && !clr_flags);
        bad_seg_d  = bad_evt_s || (bad_seg_q && !clr_flags);
    end

    // Control and status registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            seg_count_q <= 32'd0;
            gen_reset_q <= 1'b0;
            overflow_q  <= 1'b0;
            underrun_q  <= 1'b0;
            bad_seg_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            seg_count_q <= seg_count_d;
            gen_reset_q <= gen_reset_d;
            overflow_q  <= overflow_d;
            underrun_q  <= underrun_d;
            bad_seg_q   <= bad_seg_d;
        end
    end

    // Segment storage; contents are only meaningful below the occupancy count
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {wr_dt, wr_steps};
        end
    end

    always_comb begin
        dt_val    = mem_q[rd_ptr_q][63:32];
        steps_val = mem_q[rd_ptr_q][31:0];
        load      = load_s;
        gen_reset = gen_reset_q;
        full      = full_s;
        level     = count_q;
        busy      = (state_q != ST_IDLE);
        seg_count = seg_count_q;
        overflow  = overflow_q;
        underrun  = underrun_q;
        bad_seg   = bad_seg_q;
    end

endmodule

// File: tb/tb_motion_seg_queue.sv
// Bench for motion_seg_queue: a directed vector table plus multi-cycle sequences
// driven by a small behavioural step generator.
module tb_motion_seg_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] wr_dt, wr_steps;
    logic        wr_en, run, abort, clr_flags;
    logic        gen_done, gen_stopped;
    logic [31:0] dt_val, steps_val, seg_count;
    logic        load, gen_reset, full, busy, overflow, underrun, bad_seg;
    logic [4:0]  level;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    motion_seg_queue #(.DEPTH_LOG2(4)) dut (
        .clk(clk), .reset(reset), .wr_dt(wr_dt), .wr_steps(wr_steps), .wr_en(wr_en),
        .run(run), .abort(abort), .clr_flags(clr_flags), .gen_done(gen_done),
        .gen_stopped(gen_stopped), .dt_val(dt_val), .steps_val(steps_val), .load(load),
        .gen_reset(gen_reset), .full(full), .level(level), .busy(busy),
        .seg_count(seg_count), .overflow(overflow), .underrun(underrun), .bad_seg(bad_seg)
    );

    // Behavioural generator: a segment lasts dt*steps cycles, done on its last cycle
    logic        use_model;
    logic        v_done, v_stopped;
    logic [63:0] rem;
    always @(posedge clk) begin
        if (reset || gen_reset)
            rem <= 64'd0;
        else if (load)
            rem <= {32'd0, dt_val} * {32'd0, steps_val};
        else if (rem != 64'd0)
            rem <= rem - 64'd1;
    end
    assign gen_done    = use_model ? (rem == 64'd1) : v_done;
    assign gen_stopped = use_model ? (rem == 64'd0) : v_stopped;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; wr_dt = 32'd0; wr_steps = 32'd0;
        abort = 1'b0; clr_flags = 1'b0; v_done = 1'b0; v_stopped = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        run = 1'b0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic push(input logic [31:0] d, input logic [31:0] s);
        wr_en = 1'b1; wr_dt = d; wr_steps = s;
        tick();
        wr_en = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] dt, st;
        logic        run, ab, clr, dn, stp;
        logic        e_load;
        logic [31:0] e_dt, e_st;
        logic [4:0]  e_lvl;
        logic        e_busy, e_gr, e_ovf, e_und, e_bad;
        logic [31:0] e_cnt;
    } vec_t;

    function automatic vec_t mk(
        input logic we, input logic [31:0] dt, input logic [31:0] st,
        input logic rn, input logic ab, input logic clr, input logic dn, input logic stp,
        input logic el, input logic [31:0] edt, input logic [31:0] est,
        input logic [4:0] elv, input logic eb, input logic eg, input logic eo,
        input logic eu, input logic ebd, input logic [31:0] ec);
        vec_t v;
        v.we = we; v.dt = dt; v.st = st; v.run = rn; v.ab = ab; v.clr = clr;
        v.dn = dn; v.stp = stp; v.e_load = el; v.e_dt = edt; v.e_st = est;
        v.e_lvl = elv; v.e_busy = eb; v.e_gr = eg; v.e_ovf = eo; v.e_und = eu;
        v.e_bad = ebd; v.e_cnt = ec;
        return v;
    endfunction

    vec_t vecs [26];

    initial begin
        int k, n, err, chain, saw100;
        logic [31:0] last_dt;
        logic [31:0] exp_dt [3];
        logic [31:0] exp_st [3];

        //            we dt st rn ab cl dn sp | ld edt est lvl bz gr ov un bd cnt
        vecs[0]  = mk(1, 5, 7, 0, 0, 0, 0, 1,   0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 1, 0, 0, 0, 1,   1, 5, 7,  0, 1, 0, 0, 0, 0, 0);
        vecs[3]  = mk(0, 0, 0, 1, 0, 0, 0, 0,   0, 0, 0,  0, 1, 0, 0, 0, 0, 0);
        vecs[4]  = mk(1, 2, 3, 1, 0, 0, 0, 0,   0, 0, 0,  1, 1, 0, 0, 0, 0, 0);
        vecs[5]  = mk(0, 0, 0, 1, 0, 0, 1, 0,   1, 2, 3,  0, 1, 0, 0, 0, 0, 1);
        vecs[6]  = mk(0, 0, 0, 1, 0, 0, 1, 0,   0, 0, 0,  0, 0, 0, 0, 1, 0, 2);
        vecs[7]  = mk(0, 0, 0, 1, 0, 1, 0, 1,   0, 0, 0,  0, 0, 0, 0, 0, 0, 2);
        vecs[8]  = mk(1, 0, 4, 1, 0, 0, 0, 1,   0, 0, 0,  0, 0, 0, 0, 0, 1, 2);
        vecs[9]  = mk(1, 4, 0, 1, 0, 1, 0, 1,   0, 0, 0,  0, 0, 0, 0, 0, 1, 2);
        vecs[10] = mk(0, 0, 0, 1, 0, 1, 0, 1,   0, 0, 0,  0, 0, 0, 0, 0, 0, 2);
        vecs[11] = mk(1, 9, 1, 1, 1, 0, 0, 1,   0, 0, 0,  0, 1, 1, 0, 0, 0, 2);
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0,  0, 0, 0, 0, 0, 0, 2);
        vecs[13] = mk(1, 1, 1, 0, 0, 0, 0, 1,   0, 0, 0,  1, 0, 0, 0, 0, 0, 2);
        vecs[14] = mk(0, 0, 0, 1, 1, 0, 0, 1,   0, 0, 0,  0, 1, 1, 0, 0, 0, 2);
        vecs[15] = mk(0, 0, 0, 1, 0, 0, 0, 1,   0, 0, 0,  0, 0, 0, 0, 0, 0, 2);
        vecs[16] = mk(1, 3, 3, 1, 0, 0, 0, 1,   0, 0, 0,  1, 0, 0, 0, 0, 0, 2);
        vecs[17] = mk(0, 0, 0, 1, 0, 0, 0, 1,   1, 3, 3,  0, 1, 0, 0, 0, 0, 2);
        vecs[18] = mk(0, 0, 0, 1, 1, 0, 1, 0,   0, 0, 0,  0, 1, 1, 0, 0, 0, 2);
        vecs[19] = mk(0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0,  0, 0, 0, 0, 0, 0, 2);
        vecs[20] = mk(1, 6, 6, 1, 0, 0, 0, 1,   0, 0, 0,  1, 0, 0, 0, 0, 0, 2);
        vecs[21] = mk(0, 0, 0, 1, 0, 0, 0, 1,   1, 6, 6,  0, 1, 0, 0, 0, 0, 2);
        vecs[22] = mk(1, 7, 8, 0, 0, 0, 0, 0,   0, 0, 0,  1, 1, 0, 0, 0, 0, 2);
        vecs[23] = mk(0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0,  1, 0, 0, 0, 0, 0, 3);
        vecs[24] = mk(0, 0, 0, 1, 0, 0, 0, 1,   1, 7, 8,  0, 1, 0, 0, 0, 0, 3);
        vecs[25] = mk(0, 0, 0, 1, 0, 0, 1, 0,   0, 0, 0,  0, 0, 0, 0, 1, 0, 4);

        use_model = 1'b0;
        do_reset();
        #1;
        chk("reset_state", {load, level, full, busy, gen_reset, overflow, underrun, bad_seg, seg_count},
            {1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0});

        // Table: inputs applied mid-cycle, combinational load checked before the edge
        for (int i = 0; i < 26; i++) begin
            wr_en = vecs[i].we; wr_dt = vecs[i].dt; wr_steps = vecs[i].st;
            run = vecs[i].run; abort = vecs[i].ab; clr_flags = vecs[i].clr;
            v_done = vecs[i].dn; v_stopped = vecs[i].stp;
            #1;
            chk($sformatf("vec%0d_load", i), {load, load ? {dt_val, steps_val} : 64'd0},
                {vecs[i].e_load, vecs[i].e_load ? {vecs[i].e_dt, vecs[i].e_st} : 64'd0});
            tick();
            chk($sformatf("vec%0d_state", i),
                {level, busy, gen_reset, overflow, underrun, bad_seg, full, seg_count},
                {vecs[i].e_lvl, vecs[i].e_busy, vecs[i].e_gr, vecs[i].e_ovf,
                 vecs[i].e_und, vecs[i].e_bad, 1'b0, vecs[i].e_cnt});
        end

        // Single segment: load one cycle after push, done dt*steps cycles later
        use_model = 1'b1;
        do_reset();
        run = 1'b1;
        push(32'd3, 32'd2);
        #1;
        chk("t1_load", {load, dt_val, steps_val}, {1'b1, 32'd3, 32'd2});
        tick();
        run = 1'b0;
        k = 1;
        while (!gen_done && k < 50) begin tick(); k++; end
        chk("t1_duration", k, 6);
        tick();
        chk("t1_end", {seg_count, busy, underrun}, {32'd1, 1'b0, 1'b0});

        // Three chained segments: each later load lands on the done cycle
        do_reset();
        exp_dt[0] = 32'd2; exp_st[0] = 32'd2;
        exp_dt[1] = 32'd1; exp_st[1] = 32'd3;
        exp_dt[2] = 32'd4; exp_st[2] = 32'd1;
        for (int i = 0; i < 3; i++) push(exp_dt[i], exp_st[i]);
        run = 1'b1;
        #1;
        n = 0; err = 0; chain = 0; k = 0;
        while (!(n == 3 && !busy) && k < 200) begin
            if (load) begin
                if (n < 3 && (dt_val != exp_dt[n] || steps_val != exp_st[n])) err++;
                if (n > 0 && !gen_done) chain++;
                n++;
            end
            tick();
            k++;
        end
        chk("t2_loads", n, 3);
        chk("t2_order", err, 0);
        chk("t2_chained", chain, 0);
        chk("t2_count", seg_count, 32'd3);

        // Fill to full, overflow, then push while full with a simultaneous pop
        do_reset();
        for (int i = 1; i <= 16; i++) push(i, 32'd1);
        chk("t3_full", {full, level}, {1'b1, 5'd16});
        push(32'd100, 32'd1);
        chk("t3_overflow", {overflow, level}, {1'b1, 5'd16});
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk("t3_clr", overflow, 1'b0);
        run = 1'b1; wr_en = 1'b1; wr_dt = 32'd50; wr_steps = 32'd1;
        #1;
        chk("t3_pop_push", {load, dt_val}, {1'b1, 32'd1});
        tick();
        wr_en = 1'b0;
        chk("t3_level_kept", {level, overflow}, {5'd16, 1'b0});
        n = 1; saw100 = 0; last_dt = 32'd1; k = 0;
        while ((busy || level != 5'd0) && k < 2000) begin
            if (load) begin
                n++;
                last_dt = dt_val;
                if (dt_val == 32'd100) saw100++;
            end
            tick();
            k++;
        end
        chk("t3_drain", {n, saw100, last_dt}, {32'd17, 32'd0, 32'd50});

        // Abort mid-segment with queued work
        do_reset();
        for (int i = 0; i < 5; i++) push(32'd10, 32'd10);
        run = 1'b1;
        #1;
        k = 0;
        while (!load && k < 20) begin tick(); k++; end
        chk("t6_started", load, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t6_abort", {gen_reset, level, busy}, {1'b1, 5'd0, 1'b1});
        tick();
        chk("t6_idle", {gen_reset, busy}, {1'b0, 1'b0});
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (load) n++;
            tick();
        end
        chk("t6_no_load", {n, seg_count}, {32'd0, 32'd0});

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
